// File: rtl/shmem_port_master_if.sv
// shmem_port_master_if: command/response and arbiter-port signal bundle.
// master is the adapter's view; slave is the client/arbiter side.
`timescale 1ns/1ps
interface shmem_port_master_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wren;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_datain;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_dataout;
  logic                  shmem_request;
  logic                  shmem_wren;
  logic [ADDR_WIDTH-1:0] shmem_addr;
  logic [DATA_WIDTH-1:0] shmem_datain;
  logic [DATA_WIDTH-1:0] shmem_dataout;
  logic                  shmem_done;

  modport master (
    input  cmd_valid, cmd_wren, cmd_addr, cmd_datain,
    input  shmem_dataout, shmem_done,
    output cmd_ready, rsp_valid, rsp_dataout,
    output shmem_request, shmem_wren, shmem_addr, shmem_datain
  );

  modport slave (
    output cmd_valid, cmd_wren, cmd_addr, cmd_datain,
    output shmem_dataout, shmem_done,
    input  cmd_ready, rsp_valid, rsp_dataout,
    input  shmem_request, shmem_wren, shmem_addr, shmem_datain
  );
endinterface

// File: rtl/shmem_port_master.sv
// shmem_port_master: FIFO-buffered client for one shared-memory arbiter port.
// Define SHMEM_PORT_STATS_EN for saturating read/write/wait counters.
`timescale 1ns/1ps
module shmem_port_master #(
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int LOG2_FIFO_DEPTH = 2,
  parameter int READ_LATENCY    = 1
) (
  input  logic                       clk,
  input  logic                       arst_n,
  shmem_port_master_if.master        bus,
  output logic [LOG2_FIFO_DEPTH:0]   fifo_level
`ifdef SHMEM_PORT_STATS_EN
  ,
  output logic [31:0]                stat_reads,
  output logic [31:0]                stat_writes,
  output logic [31:0]                stat_wait
`endif
);

  localparam int LW = LOG2_FIFO_DEPTH + 1;
  localparam int PW = LOG2_FIFO_DEPTH;
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] ONE  = LW'(1);
  localparam logic [PW-1:0] P1   = PW'(1);

  typedef struct packed {
    logic                  wren;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                  ent_q [FIFO_DEPTH];
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_nxt;
  logic [LW-1:0]           lvl_q, lvl_d;
  logic                    rdy_q;
  logic [READ_LATENCY-1:0] tag_q, tag_d;
  logic [DATA_WIDTH-1:0]   rsp_q, rsp_d;
  logic                    cmd_rdy;
  logic                    push, pop, rd_pop, avail;
  logic                    rsp_vld;
  entry_t                  head, pres;

  // Look ahead past the head while it retires so a re-grant hits the next command
  always_comb begin
    cmd_rdy = rdy_q & (lvl_q != FULL);
    push    = bus.cmd_valid & cmd_rdy;
    rd_nxt  = rd_ptr_q + P1;
    head    = ent_q[rd_ptr_q];
    pop     = bus.shmem_done & (lvl_q != '0);
    rd_pop  = pop & ~head.wren;
    pres    = pop ? ent_q[rd_nxt] : head;
    avail   = pop ? (lvl_q > ONE) : (lvl_q != '0);
    rsp_vld = tag_q[READ_LATENCY-1];
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    lvl_d    = lvl_q;
    tag_d    = READ_LATENCY'({tag_q, rd_pop});
    rsp_d    = rsp_vld ? bus.shmem_dataout : rsp_q;
    if (push) wr_ptr_d = wr_ptr_q + P1;
    if (pop)  rd_ptr_d = rd_nxt;
    unique case ({push, pop})
      2'b10:   lvl_d = lvl_q + ONE;
      2'b01:   lvl_d = lvl_q - ONE;
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rdy_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      lvl_q    <= '0;
      tag_q    <= '0;
      rsp_q    <= '0;
    end else begin
      rdy_q    <= 1'b1;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      lvl_q    <= lvl_d;
      tag_q    <= tag_d;
      rsp_q    <= rsp_d;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) ent_q[i] <= '0;
    end else if (push) begin
      ent_q[wr_ptr_q] <= {bus.cmd_wren, bus.cmd_addr, bus.cmd_datain};
    end
  end

  assign bus.cmd_ready     = cmd_rdy;
  assign bus.shmem_request = avail;
  assign bus.shmem_wren    = pres.wren & avail;
  assign bus.shmem_addr    = pres.addr;
  assign bus.shmem_datain  = pres.data;
  assign bus.rsp_valid     = rsp_vld;
  assign bus.rsp_dataout   = rsp_d;
  assign fifo_level        = lvl_q;

`ifdef SHMEM_PORT_STATS_EN
  logic [31:0] nrd_q, nwr_q, nwait_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      nrd_q   <= '0;
      nwr_q   <= '0;
      nwait_q <= '0;
    end else begin
      if (rd_pop && nrd_q != '1)
        nrd_q <= nrd_q + 32'd1;
      if (pop && head.wren && nwr_q != '1)
        nwr_q <= nwr_q + 32'd1;
      if (avail && !bus.shmem_done && nwait_q != '1)
        nwait_q <= nwait_q + 32'd1;
    end
  end

  assign stat_reads  = nrd_q;
  assign stat_writes = nwr_q;
  assign stat_wait   = nwait_q;
`endif

endmodule
